// File: rtl/imem_loader.sv
// Boot-time loader: takes a byte stream (count header, then little-endian words) and writes it into instruction memory while holding the core.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = 8,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W-1:0] words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] n_last_q, n_last_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic handshake;
  logic go_finish, go_done, go_err;

  assign handshake = rx_valid_i & rx_ready_o;

  // NOTE: every variable written here gets a default first, so no path leaves a value held and no latch is inferred; blocking '=' is correct in combinational logic.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    n_last_d   = n_last_q;
    word_d     = word_q;
    words_d    = words_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    hold_d     = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    go_finish  = 1'b0;
    go_done    = 1'b0;
    go_err     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start_i) begin
          state_d    = S_HDR;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          busy_d     = 1'b1;
          hold_d     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_HDR: begin
        if (handshake) begin
          // Store N-1 so the end-of-image test is a plain equality on the word index.
          n_last_d = ADDR_W'(rx_data_i - 8'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = rx_data_i;
`endif
          if (rx_data_i == 8'd0)           go_finish = 1'b1;
          else if (int'(rx_data_i) > DEPTH) go_err    = 1'b1;
          else                              state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (handshake) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data_i;
`endif
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
            words_d = words_q + ADDR_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (word_idx_q == n_last_q) begin
          go_finish = 1'b1;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (handshake) begin
          if (rx_data_i == csum_q) go_done = 1'b1;
          else                     go_err  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (go_finish) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      state_d = S_CHK;
`else
      go_done = 1'b1;
`endif
    end
    if (go_done) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      hold_d  = 1'b0;
    end
    if (go_err) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      hold_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      n_last_q   <= '0;
      word_q     <= '0;
      words_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= HOLD_AT_RESET;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      n_last_q   <= n_last_d;
      word_q     <= word_d;
      words_q    <= words_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign rx_ready_o = (state_q == S_HDR) || (state_q == S_DATA);
`endif
  // The write strobe is a decode of the state register, so a partial word can never reach memory.
  assign imem_we_o      = (state_q == S_WRITE);
  assign imem_waddr_o   = word_idx_q;
  assign imem_wdata_o   = word_q;
  assign cpu_hold_o     = hold_q;
  assign load_busy_o    = busy_q;
  assign load_done_o    = done_q;
  assign load_err_o     = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle core's word-addressed instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 1-byte word-count header, then 4 bytes per instruction, little-endian.
- Assembles each 32-bit instruction and writes it into instruction memory at consecutive word addresses starting at 0.
- Holds the CPU in stall (cpu_hold) until the image is complete.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in instruction memory.
- ADDR_W, 8, instruction memory word-address width; matches the PC address width.
- HOLD_AT_RESET, 1, 1 = cpu_hold asserted out of reset; 0 = cpu_hold deasserted out of reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse that begins a load; ignored while load_busy=1.
- rx_valid  in  1  byte source has a byte on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle; transfer occurs when rx_valid & rx_ready.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  assembled instruction.
- cpu_hold  out  1  stall/reset request to the core.
- load_busy  out  1  load in progress.
- load_done  out  1  last load completed successfully; sticky until next load_start.
- load_err  out  1  last load failed; sticky until next load_start.
- words_loaded  out  ADDR_W  count of words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - load_busy=0, load_done=0, load_err=0, words_loaded=0.
  - cpu_hold=HOLD_AT_RESET.
  - Instruction memory contents are not touched.
- States: IDLE, HDR, DATA, WRITE, CHK (macro only), DONE, ERR.
- IDLE, DONE, ERR:
  - rx_ready=0.
  - load_start moves to HDR; clears load_done, load_err, words_loaded, byte index and word index; sets load_busy=1 and cpu_hold=1.
- HDR:
  - rx_ready=1; on handshake, latch N=rx_data.
  - N=0: go to DONE (or CHK if enabled); no writes.
  - N>DEPTH: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - rx_ready=1; byte k (0..3) of the word lands in bits [8k+7:8k].
  - Gaps (rx_valid=0) stall without loss.
  - After the 4th handshake, go to WRITE.
- WRITE:
  - rx_ready=0; imem_we=1 for exactly one cycle.
  - imem_waddr = word index; imem_wdata = assembled word.
  - words_loaded increments in the same cycle.
  - If word index = N-1, go to DONE (or CHK); else go to DATA with word index +1.
  - Minimum 5 cycles per word.
- DONE: load_done=1, load_busy=0, cpu_hold=0.
- ERR: load_err=1, load_busy=0, cpu_hold=1.
- Boundary conditions:
  - load_start while busy has no effect.
  - Bytes presented in IDLE/DONE/ERR are not consumed.
  - rst_n low mid-word aborts without any write; a partial word is never written.
  - Highest writable address is DEPTH-1; the word index never wraps.
- Outputs are registered; imem_we is asserted in the cycle after the 4th byte handshake.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR over the header and all data bytes.
  - After the last word (or after N=0), state CHK sets rx_ready=1 and accepts one checksum byte.
  - Byte equal to the running XOR: go to DONE. Otherwise: go to ERR.
  - Words already written remain in memory; cpu_hold stays 1.
- Undefined: no CHK state; the stream ends after the last data byte; no checksum logic is present.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with rx_valid=1.
  - Response: rx_ready=0, imem_we=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
- Two-word load:
  - Stimulus: load_start; stream 02, 83 21 40 00, 83 A0 C1 FF.
  - Response: exactly two writes, addr0=0x00402183 then addr1=0xFFC1A083; load_done=1, cpu_hold=0, words_loaded=2.
- Backpressure and gaps:
  - Stimulus: same stream as the two-word load, with rx_valid randomly low 0-3 cycles between bytes.
  - Response: identical writes; no imem_we before the 4th byte of each word.
- Header limits:
  - Stimulus: header 00.
  - Response: load_done=1 with no imem_we.
  - Stimulus: header 0x41 with DEPTH=64.
  - Response: load_err=1, cpu_hold=1, no writes, rx_ready=0 afterwards.
- Abort and restart:
  - Stimulus: rst_n pulsed low after 2 data bytes, then a full two-word load.
  - Response: no write during the aborted load; the restart writes the correct two words.
- Checksum (macro defined):
  - Stimulus: two-word stream plus checksum byte FD.
  - Response: load_done=1.
  - Stimulus: two-word stream plus checksum byte FE.
  - Response: load_err=1, cpu_hold=1.
